rip_bp_update_queue: RTL and testbench

//  In-order FIFO between fetch and execute. Records each fetched branch's predictor snapshot (index, weight, prediction).

---
 rtl/rip_branch_predictor_const.sv | 22 ++
 rtl/rip_bp_update_queue_if.sv | 41 ++++
 rtl/rip_bp_update_queue.sv | 124 ++++++++++++
 tb/tb_rip_bp_update_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rip_branch_predictor_const.sv
// ---------------------------------------------------------------------------
// rip_branch_predictor_const
//   Shared branch-predictor types.
//   bp_index_t    : predictor table index
//   bp_weight_t   : predictor weight / counter value
//   bp_snapshot_t : per-branch snapshot held in the update queue
// ---------------------------------------------------------------------------
package rip_branch_predictor_const;

    localparam int BP_INDEX_W  = 8;
    localparam int BP_WEIGHT_W = 6;

    typedef logic [BP_INDEX_W-1:0]  bp_index_t;
    typedef logic [BP_WEIGHT_W-1:0] bp_weight_t;

    typedef struct packed {
        bp_index_t  index;
        bp_weight_t weight;
        logic       pred;
    } bp_snapshot_t;

endpackage

// File: rtl/rip_bp_update_queue_if.sv
// ---------------------------------------------------------------------------
// rip_bp_update_queue_if
//   Fetch/execute-facing bus of the branch-predictor update queue.
//   push_*    : fetch side, records a branch snapshot
//   resolve_* : execute side, resolves the oldest branch
//   update_*  : predictor write port, plus resolved direction and mispredict
//   master    : pipeline side; slave : the queue
// ---------------------------------------------------------------------------
interface rip_bp_update_queue_if;
    import rip_branch_predictor_const::*;

    logic       push_valid;
    bp_index_t  push_index;
    bp_weight_t push_weight;
    logic       push_pred;
    logic       push_ready;

    logic       resolve_valid;
    logic       resolve_taken;

    logic       update;
    bp_index_t  update_index;
    bp_weight_t update_weight;
    logic       actual;
    logic       mispredict;

    modport master (
        output push_valid, push_index, push_weight, push_pred,
        output resolve_valid, resolve_taken,
        input  push_ready,
        input  update, update_index, update_weight, actual, mispredict
    );

    modport slave (
        input  push_valid, push_index, push_weight, push_pred,
        input  resolve_valid, resolve_taken,
        output push_ready,
        output update, update_index, update_weight, actual, mispredict
    );

endinterface

// File: rtl/rip_bp_update_queue.sv
// ---------------------------------------------------------------------------
// rip_bp_update_queue
//   In-order FIFO of predictor snapshots between fetch and execute. The oldest
//   entry is popped when execute resolves it; one cycle later the predictor
//   update port is driven with that entry. A mispredicted pop discards all
//   younger (wrong-path) entries.
//   clk, rstn     : clock, synchronous active-low reset
//   stall         : freezes push/resolve, suppresses update
//   flush         : empties the queue, highest priority
//   bus           : push / resolve / update signals (slave modport)
//   count         : occupancy
//   underflow_err : sticky, resolve seen while empty
// ---------------------------------------------------------------------------
module rip_bp_update_queue
    import rip_branch_predictor_const::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      stall,
    input  logic                      flush,
    rip_bp_update_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // pointers carry a wrap bit, so occupancy is simply their difference
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    bp_snapshot_t  mem_q [DEPTH];
    bp_snapshot_t  mem_d [DEPTH];

    logic          update_q, update_d;
    bp_index_t     update_index_q, update_index_d;
    bp_weight_t    update_weight_q, update_weight_d;
    logic          actual_q, actual_d;
    logic          mispredict_q, mispredict_d;
    logic          underflow_q, underflow_d;

    logic          empty, full;
    logic          pop, pop_mispredict, push;
    bp_snapshot_t  head;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign pop            = bus.resolve_valid & ~empty & ~stall & ~flush;
    assign pop_mispredict = pop & (head.pred ^ bus.resolve_taken);
    // a push racing a mispredicted pop is on the wrong path
    assign push           = bus.push_valid & ~full & ~stall & ~flush & ~pop_mispredict;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);

        rd_ptr_d = rd_ptr_q;
        if (flush || pop_mispredict) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{index:  bus.push_index,
                                        weight: bus.push_weight,
                                        pred:   bus.push_pred};
        end

        update_d        = pop;
        mispredict_d    = pop_mispredict;
        update_index_d  = update_index_q;
        update_weight_d = update_weight_q;
        actual_d        = actual_q;
        if (pop) begin
            update_index_d  = head.index;
            update_weight_d = head.weight;
            actual_d        = bus.resolve_taken;
        end

        underflow_d = underflow_q | (bus.resolve_valid & empty & ~stall & ~flush);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            update_q        <= 1'b0;
            update_index_q  <= '0;
            update_weight_q <= '0;
            actual_q        <= 1'b0;
            mispredict_q    <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            update_q        <= update_d;
            update_index_q  <= update_index_d;
            update_weight_q <= update_weight_d;
            actual_q        <= actual_d;
            mispredict_q    <= mispredict_d;
            underflow_q     <= underflow_d;
        end
    end

    // entry contents need no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.push_ready    = ~full;
    assign bus.update        = update_q;
    assign bus.update_index  = update_index_q;
    assign bus.update_weight = update_weight_q;
    assign bus.actual        = actual_q;
    assign bus.mispredict    = mispredict_q;
    assign underflow_err     = underflow_q;

endmodule

// File: tb/tb_rip_bp_update_queue.sv
module tb_rip_bp_update_queue;
    import rip_branch_predictor_const::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] index;
        logic [5:0] weight;
        logic       actual;
        logic       mis;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic stall;
    logic flush;
    logic [$clog2(DEPTH):0] count;
    logic underflow_err;

    rip_bp_update_queue_if bus_if ();

    rip_bp_update_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .stall         (stall),
        .flush         (flush),
        .bus           (bus_if),
        .count         (count),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every update pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus_if.update === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_update", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("update_index",  32'(bus_if.update_index),  32'(e.index));
                check("update_weight", 32'(bus_if.update_weight), 32'(e.weight));
                check("actual",        32'(bus_if.actual),        32'(e.actual));
                check("mispredict",    32'(bus_if.mispredict),    32'(e.mis));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_update(input logic [7:0] idx, input logic actual, input logic mis);
        exp_t e;
        e.index  = idx;
        e.weight = 6'(idx + 8'd3);
        e.actual = actual;
        e.mis    = mis;
        sb.push_back(e);
    endtask

    task automatic set_push(input logic [7:0] idx, input logic pred);
        bus_if.push_valid  = 1'b1;
        bus_if.push_index  = idx;
        bus_if.push_weight = 6'(idx + 8'd3);
        bus_if.push_pred   = pred;
    endtask

    task automatic clear_inputs();
        bus_if.push_valid    = 1'b0;
        bus_if.resolve_valid = 1'b0;
        bus_if.resolve_taken = 1'b0;
        stall                = 1'b0;
        flush                = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] idx, input logic pred);
        set_push(idx, pred);
        cyc();
        clear_inputs();
    endtask

    task automatic do_resolve(input logic taken, input logic [7:0] exp_idx, input logic exp_mis);
        expect_update(exp_idx, taken, exp_mis);
        bus_if.resolve_valid = 1'b1;
        bus_if.resolve_taken = taken;
        cyc();
        clear_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        bus_if.push_index  = '0;
        bus_if.push_weight = '0;
        bus_if.push_pred   = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rstn = 1'b1;

        // reset state
        check("rst_count",      32'(count), 32'd0);
        check("rst_update",     32'(bus_if.update), 32'd0);
        check("rst_mispredict", 32'(bus_if.mispredict), 32'd0);
        check("rst_actual",     32'(bus_if.actual), 32'd0);
        check("rst_underflow",  32'(underflow_err), 32'd0);
        check("rst_push_ready", 32'(bus_if.push_ready), 32'd1);
        check("rst_upd_index",  32'(bus_if.update_index), 32'd0);

        // 1: three pushes, three correct resolves
        do_push(8'd5, 1'b1);
        do_push(8'd6, 1'b0);
        do_push(8'd7, 1'b1);
        check("t1_count3", 32'(count), 32'd3);
        do_resolve(1'b1, 8'd5, 1'b0);
        do_resolve(1'b0, 8'd6, 1'b0);
        do_resolve(1'b1, 8'd7, 1'b0);
        check("t1_count0", 32'(count), 32'd0);

        // 2: fill, overflow push dropped, pop reopens
        for (int i = 0; i < DEPTH; i++) do_push(8'(8 + i), 1'b0);
        check("t2_full_count", 32'(count), 32'd4);
        check("t2_full_ready", 32'(bus_if.push_ready), 32'd0);
        do_push(8'd12, 1'b0);
        check("t2_drop_count", 32'(count), 32'd4);
        do_resolve(1'b0, 8'd8, 1'b0);
        check("t2_ready_again", 32'(bus_if.push_ready), 32'd1);
        check("t2_count3", 32'(count), 32'd3);
        do_resolve(1'b0, 8'd9, 1'b0);
        do_resolve(1'b0, 8'd10, 1'b0);
        do_resolve(1'b0, 8'd11, 1'b0);
        check("t2_drained", 32'(count), 32'd0);

        // 3: mispredict discards younger entries and same-cycle push
        do_push(8'd20, 1'b1);
        do_push(8'd21, 1'b1);
        do_push(8'd22, 1'b1);
        expect_update(8'd20, 1'b0, 1'b1);
        set_push(8'd23, 1'b1);
        bus_if.resolve_valid = 1'b1;
        bus_if.resolve_taken = 1'b0;
        cyc();
        clear_inputs();
        check("t3_update",   32'(bus_if.update), 32'd1);
        check("t3_mis",      32'(bus_if.mispredict), 32'd1);
        check("t3_count",    32'(count), 32'd0);
        do_push(8'd24, 1'b1);
        check("t3_one_entry", 32'(count), 32'd1);
        do_resolve(1'b1, 8'd24, 1'b0);
        check("t3_after_mis", 32'(bus_if.mispredict), 32'd0);

        // 4: flush beats push and resolve; later resolve underflows
        do_push(8'd30, 1'b0);
        do_push(8'd31, 1'b0);
        flush = 1'b1;
        set_push(8'd32, 1'b0);
        bus_if.resolve_valid = 1'b1;
        cyc();
        clear_inputs();
        check("t4_update", 32'(bus_if.update), 32'd0);
        check("t4_count",  32'(count), 32'd0);
        check("t4_no_uf",  32'(underflow_err), 32'd0);
        bus_if.resolve_valid = 1'b1;
        cyc();
        clear_inputs();
        check("t4_underflow", 32'(underflow_err), 32'd1);
        check("t4_uf_update", 32'(bus_if.update), 32'd0);
        cyc();
        check("t4_sticky", 32'(underflow_err), 32'd1);

        // 5: stall holds resolve, then exactly one update
        do_push(8'd40, 1'b1);
        do_push(8'd41, 1'b0);
        stall = 1'b1;
        bus_if.resolve_valid = 1'b1;
        bus_if.resolve_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_stall_update", 32'(bus_if.update), 32'd0);
            check("t5_stall_count",  32'(count), 32'd2);
        end
        stall = 1'b0;
        expect_update(8'd40, 1'b1, 1'b0);
        cyc();
        clear_inputs();
        check("t5_count1", 32'(count), 32'd1);
        cyc();
        check("t5_single", 32'(bus_if.update), 32'd0);
        do_resolve(1'b0, 8'd41, 1'b0);

        // 6: wrap with overlapped push/resolve pairs
        do_push(8'd50, 1'b0);
        for (int i = 1; i < 10; i++) begin
            logic p;
            p = 1'(i - 1);
            expect_update(8'(50 + i - 1), p, 1'b0);
            set_push(8'(50 + i), 1'(i));
            bus_if.resolve_valid = 1'b1;
            bus_if.resolve_taken = p;
            cyc();
            clear_inputs();
            check("t6_count", 32'(count), 32'd1);
        end
        do_resolve(1'b1, 8'd59, 1'b0);
        check("t6_empty", 32'(count), 32'd0);

        cyc();
        cyc();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
